// File: rtl/count_pwm_gen_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | count_pwm_gen_pkg : shared state encoding and sizing limits for count_pwm_gen|
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package count_pwm_gen_pkg;

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int CNT_W_DEF  = 4;
  localparam int DT_CYC_MIN = 1;
  localparam int DT_CYC_MAX = 7;

endpackage
`default_nettype wire

// File: rtl/count_pwm_gen_deadband_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | deadband_gen : delays each rising edge of the p/n pair by DT_CYC cycles     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module deadband_gen
  import count_pwm_gen_pkg::*;
#(
  parameter int DT_CYC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic run,
  output logic p,
  output logic n
);

  localparam int            CW     = $clog2(DT_CYC_MAX + 1);
  localparam logic [CW-1:0] DT_LIM = CW'(DT_CYC);

  logic [1:0] req;
  assign req = {run & ~raw, run & raw};

  // Each output goes high only after its request has been held for DT_LIM cycles,
  // so short pulses vanish and the opposite output has already fallen.
  for (genvar g = 0; g < 2; g++) begin : g_chan
    logic [CW-1:0] cnt_q;
    logic          out_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
        out_q <= 1'b0;
      end else begin
        if (req[g]) begin
          if (cnt_q != DT_LIM) cnt_q <= cnt_q + CW'(1);
        end else begin
          cnt_q <= '0;
        end
        out_q <= req[g] && (cnt_q == DT_LIM);
      end
    end
  end

  assign p = g_chan[0].out_q;
  assign n = g_chan[1].out_q;

endmodule
`default_nettype wire

// File: rtl/count_pwm_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | count_pwm_gen : PWM from a free-running count, double-buffered duty, resync |
// | Optional PWM_DEADTIME_EN adds pwm_n and rising-edge dead-time.    Rev 1.0   |
// +-----------------------------------------------------------------------------+
module count_pwm_gen
  import count_pwm_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
`ifdef PWM_DEADTIME_EN
  ,
  parameter int DT_CYC = 1
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] count,
  input  logic [CNT_W:0]   duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_out,
`ifdef PWM_DEADTIME_EN
  output logic             pwm_n,
`endif
  output logic             period_start,
  output logic             sync_err
);

  localparam logic [CNT_W:0]   DUTY_MAX = {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] prev_count_q;
  logic [CNT_W:0]   active_q, active_d;
  logic [CNT_W:0]   shadow_q, shadow_d;
  logic             shadow_full_q, shadow_full_d;
  logic             period_start_q, sync_err_q;

  logic             is_step, is_hold, is_wrap, is_jump, accept, raw;
  logic [CNT_W:0]   duty_clamped;

  always_comb begin
    is_step      = (count == prev_count_q + CNT_W'(1));
    is_hold      = (count == prev_count_q);
    is_wrap      = (prev_count_q == CNT_MAX) && (count == '0);
    is_jump      = !is_step && !is_hold;
    accept       = duty_valid && !shadow_full_q;
    duty_clamped = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;

    state_d       = state_q;
    active_d      = active_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;

    if (is_wrap && shadow_full_q) begin
      active_d      = shadow_q;
      shadow_full_d = 1'b0;
    end
    if (accept) begin
      shadow_d      = duty_clamped;
      shadow_full_d = 1'b1;
    end

    case (state_q)
      ST_SYNC: if (is_wrap) state_d = ST_RUN;
      ST_RUN:  if (is_jump) state_d = ST_SYNC;
      default: state_d = ST_SYNC;
    endcase

    // Next-state values so a new duty or a resync takes effect on count 0 itself.
    raw = (state_d == ST_RUN) && ({1'b0, count} < active_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_SYNC;
      prev_count_q   <= '0;
      active_q       <= '0;
      shadow_q       <= '0;
      shadow_full_q  <= 1'b0;
      period_start_q <= 1'b0;
      sync_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_count_q   <= count;
      active_q       <= active_d;
      shadow_q       <= shadow_d;
      shadow_full_q  <= shadow_full_d;
      period_start_q <= is_wrap;
      sync_err_q     <= (state_q == ST_RUN) && is_jump;
    end
  end

  assign duty_ready   = !shadow_full_q;
  assign period_start = period_start_q;
  assign sync_err     = sync_err_q;

`ifdef PWM_DEADTIME_EN
  deadband_gen #(
    .DT_CYC(DT_CYC)
  ) u_deadband (
    .clk(clk),
    .rst(rst),
    .raw(raw),
    .run(state_d == ST_RUN),
    .p  (pwm_out),
    .n  (pwm_n)
  );
`else
  logic pwm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_q <= 1'b0;
    else     pwm_q <= raw;
  end

  assign pwm_out = pwm_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_count_pwm_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_count_pwm_gen : directed, table-driven bench for count_pwm_gen           |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_count_pwm_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count;
  logic [4:0] duty_in;
  logic       duty_valid;
  logic       duty_ready, pwm_out, period_start, sync_err;
`ifdef PWM_DEADTIME_EN
  logic       pwm_n;
`endif

  always #5 clk = ~clk;

`ifdef PWM_DEADTIME_EN
  count_pwm_gen #(.CNT_W(4), .DT_CYC(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .count       (count),
    .duty_in     (duty_in),
    .duty_valid  (duty_valid),
    .duty_ready  (duty_ready),
    .pwm_out     (pwm_out),
    .pwm_n       (pwm_n),
    .period_start(period_start),
    .sync_err    (sync_err)
  );
`else
  count_pwm_gen #(.CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .count       (count),
    .duty_in     (duty_in),
    .duty_valid  (duty_valid),
    .duty_ready  (duty_ready),
    .pwm_out     (pwm_out),
    .period_start(period_start),
    .sync_err    (sync_err)
  );
`endif

  typedef struct {
    logic [4:0] duty;
    int         exp_high;
  } duty_vec_t;

  int         n_vec = 0;
  int         n_bad = 0;
  logic [3:0] last_cnt;
  logic       acc;
  int         prev_h;
  duty_vec_t  vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (count=%0d)", nm, act, exp, last_cnt);
    end
  endtask

  // Present the current count for one clock edge, then step the counter model.
  task automatic adv();
    acc = duty_valid && duty_ready;
    @(posedge clk);
    #1;
    last_cnt = count;
    count    = count + 4'd1;
    if (acc) duty_valid = 1'b0;
  endtask

  // Called with count==0 presented next: one full RUN period.
  task automatic check_period(input int h, input logic exp_rdy_end);
    for (int i = 0; i < 16; i++) begin
      adv();
`ifdef PWM_DEADTIME_EN
      chk("no_overlap", {31'b0, pwm_out & pwm_n}, 32'd0);
`else
      chk("pwm", {31'b0, pwm_out}, {31'b0, (int'(last_cnt) < h)});
`endif
      chk("period_start", {31'b0, period_start}, (i == 0) ? 32'd1 : 32'd0);
      chk("sync_err_idle", {31'b0, sync_err}, 32'd0);
    end
    chk("ready_end", {31'b0, duty_ready}, {31'b0, exp_rdy_end});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{5'd0,  0};
    vecs[1] = '{5'd16, 16};
    vecs[2] = '{5'd20, 16};
    vecs[3] = '{5'd31, 16};
    vecs[4] = '{5'd1,  1};
    vecs[5] = '{5'd10, 10};

    last_cnt   = '0;
    rst        = 1'b1;
    count      = '0;
    duty_in    = '0;
    duty_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pwm", {31'b0, pwm_out}, 32'd0);
    chk("rst_ps", {31'b0, period_start}, 32'd0);
    chk("rst_se", {31'b0, sync_err}, 32'd0);
    chk("rst_ready", {31'b0, duty_ready}, 32'd1);
`ifdef PWM_DEADTIME_EN
    chk("rst_pwm_n", {31'b0, pwm_n}, 32'd0);
`endif
    rst = 1'b0;

    // Duty 5 accepted in SYNC; output stays low until the first wrap.
    duty_in    = 5'd5;
    duty_valid = 1'b1;
    adv();
    chk("ready_after_accept", {31'b0, duty_ready}, 32'd0);
    chk("sync_pwm", {31'b0, pwm_out}, 32'd0);
    for (int c = 1; c < 16; c++) begin
      adv();
      chk("sync_pwm", {31'b0, pwm_out}, 32'd0);
      chk("sync_ps", {31'b0, period_start}, 32'd0);
    end
    check_period(5, 1'b1);

    // Double buffering: 3 lands at a wrap, 9 is held off while 3 waits.
    chk("ready_idle", {31'b0, duty_ready}, 32'd1);
    duty_in    = 5'd3;
    duty_valid = 1'b1;
    check_period(5, 1'b0);
    duty_in    = 5'd9;
    duty_valid = 1'b1;
    check_period(3, 1'b0);
    check_period(9, 1'b1);

    // Table of duty values including 0, full scale and clamped values.
    prev_h = 9;
    for (int v = 0; v < 6; v++) begin
      duty_in    = vecs[v].duty;
      duty_valid = 1'b1;
      check_period(prev_h, 1'b0);
      check_period(vecs[v].exp_high, 1'b1);
      prev_h = vecs[v].exp_high;
    end

    // Counter reset at count 7 while running with duty 10.
    for (int c = 0; c < 7; c++) begin
      adv();
`ifndef PWM_DEADTIME_EN
      chk("pre_jump_pwm", {31'b0, pwm_out}, {31'b0, (c < 10)});
`endif
      chk("pre_jump_se", {31'b0, sync_err}, 32'd0);
    end
    count = 4'd0;
    adv();
    chk("jump_se", {31'b0, sync_err}, 32'd1);
    chk("jump_pwm", {31'b0, pwm_out}, 32'd0);
    chk("jump_ps", {31'b0, period_start}, 32'd0);
    count = 4'd0;
    adv();
    chk("hold_se", {31'b0, sync_err}, 32'd0);
    chk("hold_pwm", {31'b0, pwm_out}, 32'd0);
    for (int c = 1; c < 16; c++) begin
      adv();
      chk("resync_pwm", {31'b0, pwm_out}, 32'd0);
      chk("resync_se", {31'b0, sync_err}, 32'd0);
      chk("resync_ps", {31'b0, period_start}, 32'd0);
    end
    check_period(10, 1'b1);

`ifdef PWM_DEADTIME_EN
    // Dead-time of 2 with duty 8, then duty 1 which must vanish.
    duty_in    = 5'd8;
    duty_valid = 1'b1;
    check_period(10, 1'b0);
    check_period(8, 1'b1);
    for (int i = 0; i < 16; i++) begin
      adv();
      chk("dt_p", {31'b0, pwm_out}, {31'b0, (last_cnt >= 4'd2) && (last_cnt < 4'd8)});
      chk("dt_n", {31'b0, pwm_n}, {31'b0, (last_cnt >= 4'd10)});
    end
    duty_in    = 5'd1;
    duty_valid = 1'b1;
    check_period(8, 1'b0);
    check_period(1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      adv();
      chk("dt_short_p", {31'b0, pwm_out}, 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
